// File: rtl/carry_lookahead_adder_32.sv
// Registered 32-bit unsigned adder: 4-bit CLA groups under a flat second-level lookahead unit.
// Optional CLA_INPUT_REG_EN adds a resettable operand register stage (2-cycle latency).
module carry_lookahead_adder_32 (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] add1_i,
    input  logic [31:0] add2_i,
    output logic [32:0] result_o
);

    logic [31:0] a;
    logic [31:0] b;

`ifdef CLA_INPUT_REG_EN
    logic [31:0] a_q;
    logic [31:0] b_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q <= 32'h0;
            b_q <= 32'h0;
        end else begin
            a_q <= add1_i;
            b_q <= add2_i;
        end
    end

    assign a = a_q;
    assign b = b_q;
`else
    assign a = add1_i;
    assign b = add2_i;
`endif

    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] c;
    logic [7:0]  gg;
    logic [7:0]  gp;
    logic [7:0]  cg;
    logic        cout;
    logic [32:0] result_d;

    assign g = a & b;
    assign p = a ^ b;

    for (genvar gi = 0; gi < 8; gi++) begin : g_grp
        localparam int B = 4 * gi;

        assign c[B]   = cg[gi];
        assign c[B+1] = g[B] | (p[B] & cg[gi]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & cg[gi]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & cg[gi]);

        assign gg[gi] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                      | (p[B+3] & p[B+2] & p[B+1] & g[B]);
        assign gp[gi] = &p[B+3:B];
    end

    // Each group carry is a flat sum-of-products over lower GG/GP terms, so it
    // never waits on a neighbouring group's carry.
    always_comb begin
        logic term;
        cg = 8'h0;
        for (int j = 1; j < 8; j++) begin
            for (int k = 0; k < j; k++) begin
                term = gg[k];
                for (int m = k + 1; m < j; m++) begin
                    term = term & gp[m];
                end
                cg[j] = cg[j] | term;
            end
        end
    end

    assign cout     = gg[7] | (gp[7] & cg[7]);
    assign result_d = {cout, p ^ c};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_o <= 33'h0;
        end else begin
            result_o <= result_d;
        end
    end

endmodule

// File: tb/tb_carry_lookahead_adder_32.sv
// Directed and random checks of carry_lookahead_adder_32 against hand values and an a+b model.
module tb_carry_lookahead_adder_32;

`ifdef CLA_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] add1;
    logic [31:0] add2;
    logic [32:0] result;

    int compared   = 0;
    int mismatched = 0;

    logic [32:0] res_m;
    logic [31:0] ia_m;
    logic [31:0] ib_m;

    carry_lookahead_adder_32 dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .add1_i  (add1),
        .add2_i  (add2),
        .result_o(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive operands/reset, advance the behavioural model, compare.
    task automatic step(input logic [31:0] a, input logic [31:0] b, input logic r);
        add1 = a;
        add2 = b;
        rst  = r;
        @(posedge clk);
        #1;
        if (LAT == 2) begin
            res_m = r ? 33'h0 : ({1'b0, ia_m} + {1'b0, ib_m});
            ia_m  = r ? 32'h0 : a;
            ib_m  = r ? 32'h0 : b;
        end else begin
            res_m = r ? 33'h0 : ({1'b0, a} + {1'b0, b});
        end
        expect_eq("model", result, res_m);
    endtask

    task automatic check_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [32:0] exp);
        for (int i = 0; i < LAT; i++) step(a, b, 1'b0);
        expect_eq(tag, result, exp);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        rst  = 1'b1;
        add1 = 32'hFFFF_FFFF;
        add2 = 32'hFFFF_FFFF;

        // Reset with all-ones operands
        step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        expect_eq("reset_0", result, 33'h0);
        step(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        expect_eq("reset_1", result, 33'h0);
        check_vec("post_reset", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE);

        check_vec("no_carry",   32'h29AF_2430, 32'h7A1B_9ABC, 33'h0_A3CA_BEEC);
        check_vec("propagate",  32'h5555_5555, 32'hAAAA_AAAA, 33'h0_FFFF_FFFF);
        check_vec("cout_a",     32'h8943_DEAF, 32'hDAAD_BAAD, 33'h1_63F1_995C);
        check_vec("cout_b",     32'h8051_9860, 32'h8086_BA3E, 33'h1_00D8_529E);
        check_vec("ripple_all", 32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000);
        check_vec("ripple_sw",  32'h0000_0001, 32'hFFFF_FFFF, 33'h1_0000_0000);
        check_vec("plus_one",   32'h0000_0001, 32'hDEAF_BEEF, 33'h0_DEAF_BEF0);
        check_vec("ident_a",    32'hABCD_1234, 32'h0000_0000, 33'h0_ABCD_1234);
        check_vec("ident_b",    32'h0000_0000, 32'h1234_5678, 33'h0_1234_5678);
        check_vec("comm_ab",    32'h8943_DEAF, 32'hDAAD_BAAD, 33'h1_63F1_995C);
        check_vec("comm_ba",    32'hDAAD_BAAD, 32'h8943_DEAF, 33'h1_63F1_995C);

        // Back-to-back stream
        step(32'h0000_0010, 32'h0000_0001, 1'b0);
        step(32'h0000_0020, 32'h0000_0002, 1'b0);
        step(32'h0000_0030, 32'h0000_0003, 1'b0);
        step(32'h0000_0040, 32'h0000_0004, 1'b0);
        if (LAT == 1) expect_eq("stream_last", result, 33'h0_0000_0044);
        else          expect_eq("stream_last", result, 33'h0_0000_0033);

        // Mid-stream one-cycle reset; operand pair 7000_0000+0700_0000 must be discarded
        step(32'h7000_0000, 32'h0700_0000, 1'b1);
        expect_eq("mid_rst", result, 33'h0);
        step(32'h0000_0100, 32'h0000_0200, 1'b0);
        if (LAT == 1) expect_eq("after_rst", result, 33'h0_0000_0300);
        else          expect_eq("after_rst", result, 33'h0);
        step(32'h0000_0400, 32'h0000_0800, 1'b0);
        if (LAT == 1) expect_eq("after_rst2", result, 33'h0_0000_0C00);
        else          expect_eq("after_rst2", result, 33'h0_0000_0300);

        // Random streaming against the model, swapped order every other cycle
        for (int i = 0; i < 10000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 50 == 7) rb = ~ra;
            if (i % 2 == 1) step(rb, ra, 1'b0);
            else            step(ra, rb, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/carry_lookahead_adder_32.md
# carry_lookahead_adder_32

Registered 32-bit unsigned adder built from a two-level carry-lookahead network. It produces a 33-bit sum, with the carry-out as the MSB, on a clock edge. It is the reference exact adder of the adders32 family: approximate adders are compared against its result, and it serves as a drop-in datapath adder where a one-cycle registered sum is acceptable.

## Interface
- No parameters; the width is fixed at 32.
- clk_i  input  1  clock; all state updates on the rising edge
- rst_i  input  1  synchronous reset, active-high
- add1_i  input  32  addend A, unsigned
- add2_i  input  32  addend B, unsigned
- result_o  output  33  registered sum; result_o[32] is the carry-out, result_o[31:0] is the sum bits

## Operation
- Per bit: g[i] = a[i] & b[i]; p[i] = a[i] ^ b[i].
- Level 1: eight 4-bit CLA groups.
  - Each group computes its internal carries from g/p and its group carry-in.
  - Each group also outputs group generate GG and group propagate GP.
- Level 2: a lookahead unit computes the carry-in of each group from GG/GP, with carry-in of group 0 = 0.
  - Group carries must not ripple group-to-group.
- sum[i] = p[i] ^ c[i]; carry-out = carry of bit 31.
- No carry-in port and no overflow flag. The 33-bit result is always exact: result = add1_i + add2_i, in the range 0 .. 0x1_FFFF_FFFE.
- Addition is commutative; swapping the inputs must give an identical result_o.
- Reset:
  - While rst_i = 1 at a rising edge, result_o <= 33'h0, regardless of the inputs.
  - Reset takes priority over any in-flight sum. A sum being computed when reset asserts is discarded and never appears on result_o.
- No handshake: a new operand pair is accepted on every clock, so throughput is one addition per cycle.

## Timing
- Reset value of result_o: 33'h0_0000_0000.
- Default latency is 1 cycle. Operands present before rising edge N appear on result_o after edge N, and hold until the next edge.
- result_o is driven directly from flops. No combinational path from the inputs to result_o.
- First valid result: the first edge after the edge at which rst_i was sampled low.
- Inputs changing several times within one clock period: only the value present at the edge (meeting setup) is summed.
- Critical path: bit g/p, then group GG/GP, then level-2 lookahead, then group internal carry, then sum XOR. It must not scale linearly with width.

## Configuration
- CLA_INPUT_REG_EN defined:
  - add1_i and add2_i are first captured in input registers, which reset synchronously to 0.
  - The CLA operates register-to-register; latency is 2 cycles.
  - Reset clears both stages, so result_o reads 0 for the first two edges after reset deasserts unless valid operands were applied during the first post-reset cycle.
- CLA_INPUT_REG_EN undefined: no input registers; latency is 1 cycle as specified above.
- Function, width and reset value are identical in both builds.

## Test plan
- Reset: assert rst_i for 2 cycles with add1_i = 32'hFFFF_FFFF and add2_i = 32'hFFFF_FFFF -> result_o = 33'h0 throughout; after release -> 33'h1_FFFF_FFFE one latency later.
- No-carry and propagate chain:
  - 29AF_2430 + 7A1B_9ABC -> 0_A3CA_BEEC.
  - 5555_5555 + AAAA_AAAA -> 0_FFFF_FFFF, every bit propagating with no carry.
- Carry-out:
  - 8943_DEAF + DAAD_BAAD -> 1_63F1_995C.
  - 8051_9860 + 8086_BA3E -> 1_00D8_529E.
- Full-width ripple through the lookahead: FFFF_FFFF + 0000_0001 -> 1_0000_0000; 0000_0001 + DEAF_BEEF -> 0_DEAF_BEF0.
- Identity and commutativity: ABCD_1234 + 0 -> 0_ABCD_1234; 0 + 1234_5678 -> 0_1234_5678; swapped operands give equal results.
- Streaming and mid-stream reset:
  - Back-to-back operand changes every cycle -> each sum appears exactly one latency later, in order.
  - rst_i pulsed for one cycle mid-stream -> result_o = 0 at that edge, and the discarded operand's sum never appears.
  - Compare against a behavioural a+b model over ≥10k random vectors in both configuration builds.
